// File: rtl/quad_step_monitor_if.sv
// quad_step_monitor_if
//   Bundles the sequencer state bus, the clear strobe and the monitor's
//   registered results so the monitor and its consumer share one port.
//
//   Handshake: none. `state` and `clr` are sampled on every rising clk edge
//   with no valid/ready qualification; every output is a register that
//   changes only on that edge. The slave side never back-pressures.
//
//   master : drives state/clr, observes results (sequencer side / bench)
//   slave  : the monitor itself
//   dbg_prev exposes the monitor's internal copy of the previous state.
interface quad_step_monitor_if #(
  parameter int POS_W = 8,
  parameter int ERR_W = 4
);
  logic [1:0]       state;
  logic             clr;
  logic [POS_W-1:0] position;
  logic             dir;
  logic             step_valid;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic             stall;
  logic [1:0]       dbg_prev;

  modport master (
    output state, clr,
    input  position, dir, step_valid, err, err_cnt, stall, dbg_prev
  );

  modport slave (
    input  state, clr,
    output position, dir, step_valid, err, err_cnt, stall, dbg_prev
  );
endinterface

// File: rtl/quad_step_monitor.sv
// quad_step_monitor
//   Watches the 2-bit Gray-coded state of the upstream sequencer. Single-bit
//   transitions are forward/backward steps accumulated into a wrapping
//   position; two-bit jumps are counted as errors; a stall flag rises after
//   STALL_CYC consecutive cycles without a legal step.
//
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high reset
//     bus    : quad_step_monitor_if.slave
//              in : state[1:0], clr
//              out: position, dir, step_valid, err, err_cnt, stall, dbg_prev
module quad_step_monitor #(
  parameter int POS_W     = 8,
  parameter int ERR_W     = 4,
  parameter int STALL_CYC = 16
) (
  input logic                clk,
  input logic                reset,
  quad_step_monitor_if.slave bus
);

  localparam int               SC_W      = $clog2(STALL_CYC + 1);
  localparam logic [SC_W-1:0]  STALL_MAX = SC_W'(STALL_CYC);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    STEP_IDLE,
    STEP_FWD,
    STEP_BWD,
    STEP_ILLEGAL
  } step_e;

  logic [1:0]       prev_q;
  logic [POS_W-1:0] position_q;
  logic             dir_q;
  logic             step_valid_q;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [SC_W-1:0]  stall_cnt_q;
  logic             stall_q;

  step_e           step_kind;
  logic [SC_W-1:0] stall_cnt_inc;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; backward is the reverse.
  always_comb begin
    step_kind = STEP_IDLE;
    case ({prev_q, bus.state})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_kind = STEP_FWD;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_kind = STEP_BWD;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_kind = STEP_ILLEGAL;
      default:                                step_kind = STEP_IDLE;
    endcase
  end

  // Stall counter saturates at STALL_CYC; stall is high exactly while it sits there.
  always_comb begin
    stall_cnt_inc = stall_cnt_q;
    if (stall_cnt_q != STALL_MAX) stall_cnt_inc = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= 2'b00;
      position_q   <= '0;
      dir_q        <= 1'b1;
      step_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      stall_q      <= 1'b0;
    end else begin
      prev_q       <= bus.state;
      step_valid_q <= 1'b0;

      case (step_kind)
        STEP_FWD: begin
          position_q   <= position_q + 1'b1;
          dir_q        <= 1'b1;
          step_valid_q <= 1'b1;
          stall_cnt_q  <= '0;
          stall_q      <= 1'b0;
        end
        STEP_BWD: begin
          position_q   <= position_q - 1'b1;
          dir_q        <= 1'b0;
          step_valid_q <= 1'b1;
          stall_cnt_q  <= '0;
          stall_q      <= 1'b0;
        end
        STEP_ILLEGAL: begin
          // A jump is not progress, so it also feeds the stall counter.
          err_q       <= 1'b1;
          if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 1'b1;
          stall_cnt_q <= stall_cnt_inc;
          stall_q     <= (stall_cnt_inc == STALL_MAX);
        end
        default: begin
          stall_cnt_q <= stall_cnt_inc;
          stall_q     <= (stall_cnt_inc == STALL_MAX);
        end
      endcase

      // clr overrides bookkeeping but leaves dir/step_valid/prev from this edge.
      if (bus.clr) begin
        position_q  <= '0;
        err_q       <= 1'b0;
        err_cnt_q   <= '0;
        stall_cnt_q <= '0;
        stall_q     <= 1'b0;
      end
    end
  end

  assign bus.position   = position_q;
  assign bus.dir        = dir_q;
  assign bus.step_valid = step_valid_q;
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.stall      = stall_q;
  assign bus.dbg_prev   = prev_q;

endmodule

// File: tb/tb_quad_step_monitor.sv
// tb_quad_step_monitor
//   Table-driven vectors, hand-written corner sequences and a randomized
//   run, all checked against a Gray-index reference model.
module tb_quad_step_monitor;

  localparam int POS_W     = 8;
  localparam int ERR_W     = 4;
  localparam int STALL_CYC = 16;
  localparam int POS_MOD   = 1 << POS_W;
  localparam int ERR_SAT   = (1 << ERR_W) - 1;
  localparam int W         = POS_W + ERR_W + 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  quad_step_monitor_if #(.POS_W(POS_W), .ERR_W(ERR_W)) bus ();

  quad_step_monitor #(
    .POS_W(POS_W), .ERR_W(ERR_W), .STALL_CYC(STALL_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Position on the Gray cycle; the step is the distance around the ring.
  logic [1:0] m_prev;
  int m_pos, m_cnt, m_since;
  bit m_dir, m_sv, m_err, m_stall;

  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = 2'b00; m_pos = 0; m_dir = 1; m_sv = 0;
    m_err = 0; m_cnt = 0; m_since = 0; m_stall = 0;
  endtask

  task automatic model_update(input logic [1:0] s, input logic c);
    int d;
    d = (gidx(s) - gidx(m_prev) + 4) % 4;
    m_sv = 0;
    if (d == 1) begin
      m_pos = (m_pos + 1) % POS_MOD; m_dir = 1; m_sv = 1; m_since = 0;
    end else if (d == 3) begin
      m_pos = (m_pos + POS_MOD - 1) % POS_MOD; m_dir = 0; m_sv = 1; m_since = 0;
    end else begin
      if (m_since < STALL_CYC) m_since++;
      if (d == 2) begin
        m_err = 1;
        if (m_cnt < ERR_SAT) m_cnt++;
      end
    end
    if (c) begin
      m_pos = 0; m_err = 0; m_cnt = 0; m_since = 0;
    end
    m_stall = (m_since >= STALL_CYC);
    m_prev  = s;
  endtask

  function automatic logic [W-1:0] model_vec();
    return {m_pos[POS_W-1:0], m_dir, m_sv, m_err, m_cnt[ERR_W-1:0], m_stall};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {bus.position, bus.dir, bus.step_valid, bus.err, bus.err_cnt, bus.stall};
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_compare(input string name);
    logic [W-1:0] e, a;
    e = exp_q.pop_front();
    a = dut_vec();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got pos=%0d dir=%0b sv=%0b err=%0b cnt=%0d stall=%0b expected pos=%0d dir=%0b sv=%0b err=%0b cnt=%0d stall=%0b (t=%0t)",
               name, a[W-1 -: POS_W], a[ERR_W+3], a[ERR_W+2], a[ERR_W+1], a[ERR_W:1], a[0],
               e[W-1 -: POS_W], e[ERR_W+3], e[ERR_W+2], e[ERR_W+1], e[ERR_W:1], e[0], $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs already on the bus; let one edge happen and check 1 ns later.
  task automatic edge_and_check(input string name);
    @(posedge clk);
    model_update(bus.state, bus.clr);
    exp_q.push_back(model_vec());
    #1;
    sb_compare(name);
  endtask

  task automatic step(input logic [1:0] s, input logic c, input string name);
    @(negedge clk);
    bus.state = s;
    bus.clr   = c;
    edge_and_check(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] st;
    logic       clr;
    int         pos;
    logic       dir;
    logic       sv;
    logic       err;
    int         ecnt;
    logic       stall;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [1:0] cur;

    tbl[0] = '{2'b00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[2] = '{2'b11, 1'b0, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[3] = '{2'b10, 1'b0, 3, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[4] = '{2'b00, 1'b0, 4, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[5] = '{2'b01, 1'b0, 5, 1'b1, 1'b1, 1'b0, 0, 1'b0};

    reset     = 1'b1;
    bus.state = 2'b00;
    bus.clr   = 1'b0;
    model_reset();
    #12;
    check("reset_position", int'(bus.position), 0);
    check("reset_dir", int'(bus.dir), 1);
    check("reset_sv", int'(bus.step_valid), 0);
    check("reset_err", int'(bus.err), 0);
    check("reset_err_cnt", int'(bus.err_cnt), 0);
    check("reset_stall", int'(bus.stall), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: forward walk from the table
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].st, tbl[i].clr, "tbl_model");
      check("tbl_pos", int'(bus.position), tbl[i].pos);
      check("tbl_dir", int'(bus.dir), int'(tbl[i].dir));
      check("tbl_sv", int'(bus.step_valid), int'(tbl[i].sv));
      check("tbl_err", int'(bus.err), int'(tbl[i].err));
      check("tbl_err_cnt", int'(bus.err_cnt), tbl[i].ecnt);
      check("tbl_stall", int'(bus.stall), int'(tbl[i].stall));
    end

    // 2: backward wrap below zero (01->00 backward under clr -> pos 0)
    step(2'b00, 1'b1, "t2_clr");
    step(2'b00, 1'b0, "t2_idle");
    step(2'b10, 1'b0, "t2_back1");
    check("t2_wrap_pos", int'(bus.position), 255);
    check("t2_dir", int'(bus.dir), 0);
    check("t2_sv", int'(bus.step_valid), 1);
    step(2'b11, 1'b0, "t2_back2");
    check("t2_pos254", int'(bus.position), 254);

    // 3: illegal jumps and err_cnt saturation (walk forward to 00 first)
    step(2'b10, 1'b0, "t3_fwd1");
    step(2'b00, 1'b0, "t3_fwd2");
    check("t3_pos_wrap_up", int'(bus.position), 0);
    step(2'b11, 1'b0, "t3_illegal");
    check("t3_err", int'(bus.err), 1);
    check("t3_err_cnt", int'(bus.err_cnt), 1);
    check("t3_pos_hold", int'(bus.position), 0);
    check("t3_no_sv", int'(bus.step_valid), 0);
    for (int i = 0; i < 20; i++)
      step((i % 2 == 0) ? 2'b00 : 2'b11, 1'b0, "t3_alt");
    check("t3_err_sat", int'(bus.err_cnt), ERR_SAT);

    // 4: stall after STALL_CYC idle cycles, cleared by a legal step
    step(2'b01, 1'b0, "t4_back");
    check("t4_sv", int'(bus.step_valid), 1);
    for (int i = 1; i <= STALL_CYC + 3; i++) begin
      step(2'b01, 1'b0, "t4_hold");
      if (i == STALL_CYC - 1) check("t4_stall_not_yet", int'(bus.stall), 0);
      if (i == STALL_CYC)     check("t4_stall_rise", int'(bus.stall), 1);
    end
    check("t4_stall_stays", int'(bus.stall), 1);
    step(2'b11, 1'b0, "t4_step");
    check("t4_stall_drop", int'(bus.stall), 0);
    check("t4_sv_same", int'(bus.step_valid), 1);

    // 5: clr together with a legal step, from pos 7 with err set
    step(2'b01, 1'b1, "t5_clr");
    step(2'b10, 1'b0, "t5_ill1");
    step(2'b01, 1'b0, "t5_ill2");
    step(2'b11, 1'b0, "t5_f1");
    step(2'b10, 1'b0, "t5_f2");
    step(2'b00, 1'b0, "t5_f3");
    step(2'b01, 1'b0, "t5_f4");
    step(2'b11, 1'b0, "t5_f5");
    step(2'b10, 1'b0, "t5_f6");
    step(2'b00, 1'b0, "t5_f7");
    check("t5_pre_pos", int'(bus.position), 7);
    check("t5_pre_err", int'(bus.err), 1);
    step(2'b01, 1'b1, "t5_clr_step");
    check("t5_pos", int'(bus.position), 0);
    check("t5_err", int'(bus.err), 0);
    check("t5_err_cnt", int'(bus.err_cnt), 0);
    check("t5_dir", int'(bus.dir), 1);
    check("t5_sv", int'(bus.step_valid), 1);

    // 6: asynchronous reset mid-cycle with pos 3, state 11
    step(2'b10, 1'b0, "t6_ill");
    step(2'b00, 1'b0, "t6_f1");
    step(2'b01, 1'b0, "t6_f2");
    step(2'b11, 1'b0, "t6_f3");
    check("t6_pre_pos", int'(bus.position), 3);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_rst_pos", int'(bus.position), 0);
    check("t6_rst_dir", int'(bus.dir), 1);
    check("t6_rst_err", int'(bus.err), 0);
    check("t6_rst_prev", int'(bus.dbg_prev), 0);
    @(negedge clk);
    reset = 1'b0;
    edge_and_check("t6_first_edge");
    check("t6_err", int'(bus.err), 1);
    check("t6_err_cnt", int'(bus.err_cnt), 1);

    // randomized run, biased towards holding the state so stalls occur
    cur = 2'b11;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 5) == 0) cur = 2'($urandom_range(0, 3));
        else if ($urandom_range(0, 1) == 0) cur = {cur[0], ~cur[1]};
        else cur = {~cur[0], cur[1]};
      end
      if (i % 100 < 30) cur = bus.state;  // long holds to reach stall
      step(cur, ($urandom_range(0, 40) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
